// File: rtl/scanline_buffer_writer.sv
// ---------------------------------------------------------------------------
// scanline_buffer_writer
//
// System-clock producer for the VGA scanline double buffer. Rendered pixels
// arrive on a valid/ready stream. They are written into one of two line
// banks: bank 0 starts at word 0 and bank 1 starts at word LINE_WIDTH. The
// VGA output stage reads those banks.
//
// The writer starts a frame on frame_start. It prefills both banks after
// render_start. It then frees one bank each time the display has shown that
// bank for 2 or 4 scanlines. underrun is set when the display moves on to a
// bank that is not completely written.
//
// Ports:
//   sys_clk, reset_n          clock; asynchronous active-low reset
//   frame_start               pulse: start of VGA frame, returns to IDLE
//   render_start              pulse: playfield begins, requests both banks
//   scanline_start            pulse: one per displayed VGA scanline
//   pixel_scale               0: bank shown 2 lines, 1: 4 lines (latched)
//   line_req / line_bank      renderer may supply pixels for line_bank
//   pix_valid/pix_data/
//   pix_ready                 renderer pixel stream (RGB565)
//   buf_we/buf_addr/buf_data  registered line buffer write port
//   underrun                  sticky flag, cleared by frame_start
// ---------------------------------------------------------------------------
module scanline_buffer_writer #(
    parameter int LINE_WIDTH = 640,
    parameter int ADDR_W     = 11
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              render_start,
    input  logic              scanline_start,
    input  logic              pixel_scale,
    output logic              line_req,
    output logic              line_bank,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    output logic              pix_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [15:0]       buf_data,
    output logic              underrun
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN
    } state_t;

    state_t            state;
    logic [1:0]        free_banks;   // banks the renderer may still fill, 0..2
    logic              wbank;
    logic [ADDR_W-1:0] x;
    logic [2:0]        sl_cnt;       // scanlines shown from the current bank
    logic              scale_l;

    logic              accept;
    logic              complete;
    logic              rel;
    logic [2:0]        sl_inc;
    logic [2:0]        lpb;
    logic [1:0]        fb_eff;
    logic [1:0]        fb_next;

    // The ready signal depends only on registered state. This keeps it free of
    // any combinational path from pix_valid.
    assign pix_ready = (state != IDLE) && (free_banks != 2'd0);
    assign line_req  = pix_ready;
    assign line_bank = wbank;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        accept   = pix_valid && pix_ready;
        complete = accept && (x == ADDR_W'(LINE_WIDTH - 1));
        sl_inc   = sl_cnt + 3'd1;
        lpb      = scale_l ? 3'd4 : 3'd2;
        rel      = (state == RUN) && scanline_start && (sl_inc == lpb);
        // A bank completed in the same cycle is already accounted for here.
        // As a result, a completion and a release in one cycle cancel out.
        fb_eff   = free_banks - {1'b0, complete};
        fb_next  = fb_eff;
        if (rel) begin
            fb_next = (fb_eff == 2'd2) ? 2'd2 : fb_eff + 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers therefore update together from the values sampled at the
    // edge.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            free_banks <= 2'd0;
            wbank      <= 1'b0;
            x          <= '0;
            sl_cnt     <= 3'd0;
            scale_l    <= 1'b0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= 16'd0;
            underrun   <= 1'b0;
        end else if (render_start) begin
            // render_start takes priority over a coincident frame_start.
            state      <= ARMED;
            free_banks <= 2'd2;
            wbank      <= 1'b0;
            x          <= '0;
            sl_cnt     <= 3'd0;
            scale_l    <= pixel_scale;
            buf_we     <= 1'b0;
        end else if (frame_start) begin
            // Any line in progress is dropped. No further writes are issued.
            state      <= IDLE;
            free_banks <= 2'd0;
            wbank      <= 1'b0;
            x          <= '0;
            underrun   <= 1'b0;
            buf_we     <= 1'b0;
        end else begin
            buf_we <= accept;
            if (accept) begin
                buf_addr <= (wbank ? ADDR_W'(LINE_WIDTH) : '0) + x;
                buf_data <= pix_data;
                if (complete) begin
                    x     <= '0;
                    wbank <= ~wbank;
                end else begin
                    x <= x + 1'b1;
                end
            end

            free_banks <= fb_next;

            if (scanline_start) begin
                if (state == ARMED) begin
                    // The first scanline puts bank 0 on screen. Nothing is
                    // released yet.
                    state  <= RUN;
                    sl_cnt <= 3'd0;
                end else if (state == RUN) begin
                    sl_cnt <= rel ? 3'd0 : sl_inc;
                end
            end

            // The display has moved on to a bank the renderer has not
            // finished.
            if (rel && (fb_eff != 2'd0)) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scanline_buffer_writer.sv
module tb_scanline_buffer_writer;

    localparam int LINE_WIDTH = 640;
    localparam int ADDR_W     = 11;

    logic              sys_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              render_start = 1'b0;
    logic              scanline_start = 1'b0;
    logic              pixel_scale = 1'b0;
    logic              line_req;
    logic              line_bank;
    logic              pix_valid = 1'b0;
    logic [15:0]       pix_data = 16'd0;
    logic              pix_ready;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [15:0]       buf_data;
    logic              underrun;

    int n_checks = 0;
    int n_pass   = 0;

    scanline_buffer_writer #(
        .LINE_WIDTH(LINE_WIDTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .sys_clk       (sys_clk),
        .reset_n       (reset_n),
        .frame_start   (frame_start),
        .render_start  (render_start),
        .scanline_start(scanline_start),
        .pixel_scale   (pixel_scale),
        .line_req      (line_req),
        .line_bank     (line_bank),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .buf_we        (buf_we),
        .buf_addr      (buf_addr),
        .buf_data      (buf_data),
        .underrun      (underrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance one edge. Outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_render(input logic scale);
        pixel_scale  = scale;
        render_start = 1'b1;
        tick();
        render_start = 1'b0;
    endtask

    task automatic pulse_sl();
        scanline_start = 1'b1;
        tick();
        scanline_start = 1'b0;
        tick();
    endtask

    // Streams n back-to-back pixels. Each write must appear one cycle after
    // its accept, with the address and data given.
    task automatic stream(input int n, input int addr0, input int data0);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'(data0 + i);
            check("stream_ready", 32'(pix_ready), 32'd1);
            tick();
            check("stream_we",   32'(buf_we),   32'd1);
            check("stream_addr", 32'(buf_addr), 32'(addr0 + i));
            check("stream_data", 32'(buf_data), 32'(16'(data0 + i)));
        end
        pix_valid = 1'b0;
        tick();
        check("stream_idle_we", 32'(buf_we), 32'd0);
    endtask

    initial begin
        // 1. Reset, a partial line, then an asynchronous reset in the middle
        //    of that line.
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_ready", 32'(pix_ready), 32'd0);
        pulse_render(1'b0);
        check("armed_ready", 32'(pix_ready), 32'd1);
        stream(100, 0, 16'h0100);
        #2 reset_n = 1'b0;
        #1;
        check("rst_outputs", {26'd0, line_req, line_bank, pix_ready, buf_we, underrun, 1'b0}, 32'd0);
        check("rst_addr", 32'(buf_addr), 32'd0);
        check("rst_data", 32'(buf_data), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        pix_valid = 1'b1;
        pulse_sl();
        check("idle_after_rst_ready", 32'(pix_ready), 32'd0);
        check("idle_after_rst_we", 32'(buf_we), 32'd0);
        pix_valid = 1'b0;

        // 2. Prefill both banks with data equal to the pixel index.
        pulse_render(1'b0);
        stream(1280, 0, 0);
        check("prefill_ready_low", 32'(pix_ready), 32'd0);

        // 3. Scale 2: the second pulse after display start frees bank 0.
        pulse_sl();
        check("s2_disp_start", 32'(pix_ready), 32'd0);
        pulse_sl();
        check("s2_no_release_yet", 32'(line_req), 32'd0);
        pulse_sl();
        check("s2_release_req", 32'(line_req), 32'd1);
        check("s2_release_bank", 32'(line_bank), 32'd0);
        check("s2_no_underrun", 32'(underrun), 32'd0);
        stream(3, 0, 16'h1000);

        // 5. Withhold pixels. The next release underruns, and the release
        //    after that saturates free_banks at 2.
        pulse_sl();
        pulse_sl();
        check("ur_set", 32'(underrun), 32'd1);
        pulse_sl();
        pulse_sl();
        check("ur_sticky", 32'(underrun), 32'd1);
        stream(637, 3, 16'h2000);
        check("sat_bank1", 32'(line_bank), 32'd1);
        stream(640, 640, 16'h3000);
        check("sat_ready_low", 32'(pix_ready), 32'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_clears_ur", 32'(underrun), 32'd0);
        check("fs_idle", 32'(pix_ready), 32'd0);

        // 4. Scale 4 is latched. Changing the live input afterwards does
        //    nothing.
        pulse_render(1'b1);
        pixel_scale = 1'b0;
        stream(1280, 0, 16'h4000);
        pulse_sl();
        pulse_sl();
        pulse_sl();
        check("s4_pulse2", 32'(line_req), 32'd0);
        pulse_sl();
        check("s4_pulse3", 32'(line_req), 32'd0);
        pulse_sl();
        check("s4_release", 32'(line_req), 32'd1);
        check("s4_no_underrun", 32'(underrun), 32'd0);

        // 6. The last pixel of a line and a release in the same cycle, with
        //    free_banks=1.
        stream(639, 0, 16'h5000);
        pulse_sl();
        pulse_sl();
        pulse_sl();
        pix_valid      = 1'b1;
        pix_data       = 16'hBEEF;
        scanline_start = 1'b1;
        tick();
        pix_valid      = 1'b0;
        scanline_start = 1'b0;
        check("coinc_we", 32'(buf_we), 32'd1);
        check("coinc_addr", 32'(buf_addr), 32'd639);
        check("coinc_data", 32'(buf_data), 32'hBEEF);
        check("coinc_bank", 32'(line_bank), 32'd1);
        check("coinc_ready", 32'(pix_ready), 32'd1);
        check("coinc_no_underrun", 32'(underrun), 32'd0);
        stream(640, 640, 16'h6000);
        check("coinc_full", 32'(pix_ready), 32'd0);

        // render_start beats a coincident frame_start.
        frame_start  = 1'b1;
        render_start = 1'b1;
        tick();
        frame_start  = 1'b0;
        render_start = 1'b0;
        check("rs_wins_ready", 32'(pix_ready), 32'd1);
        check("rs_wins_bank", 32'(line_bank), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scanline_buffer_writer.md
Name: scanline_buffer_writer

Overview:
- Sys-clock-side producer for the VGA scanline double buffer. It writes rendered lines into the two line banks, at word 0 and word LINE_WIDTH, that the VGA output stage reads out.
- It is paced by the frame_start, render_start and scanline_start pulses from the VGA timing domain, and it releases banks as the display consumes them.
- It accepts pixels from the renderer over a valid/ready stream and flags underruns.

Parameters:
LINE_WIDTH, 640, pixels per line and base address of bank 1
ADDR_W, 11, line buffer address width

Ports:
sys_clk  in  1  system clock; the only clock
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse, start of VGA frame (already in sys_clk domain)
render_start  in  1  one-cycle pulse, playfield about to begin
scanline_start  in  1  one-cycle pulse, one per VGA scanline
pixel_scale  in  1  0: each bank is shown for 2 scanlines; 1: for 4 scanlines
line_req  out  1  renderer may supply pixels for the line in line_bank
line_bank  out  1  bank currently being written
pix_valid  in  1  renderer pixel valid
pix_data  in  16  RGB565 pixel
pix_ready  out  1  writer accepts pixel
buf_we  out  1  line buffer write enable
buf_addr  out  ADDR_W  line buffer write address
buf_data  out  16  line buffer write data
underrun  out  1  sticky: display switched to an incomplete bank

Behaviour:
- Reset (async, reset_n=0): state=IDLE, free_banks=0, wbank=0, x=0, sl_cnt=0. Outputs: line_req=0, line_bank=0, pix_ready=0, buf_we=0, buf_addr=0, buf_data=0, underrun=0.
- States:
  - IDLE: pix_ready=0; ignores scanline_start.
  - ARMED: both banks requested; waiting for the first scanline_start.
  - RUN: display active.
- render_start, from any state:
  - free_banks<=2, wbank<=0, x<=0, sl_cnt<=0.
  - scale_l<=pixel_scale (latched; the live input is ignored afterwards).
  - state<=ARMED.
- frame_start, from any state: state<=IDLE, free_banks<=0, wbank<=0, x<=0, underrun<=0. A line in progress is abandoned with no further writes.
- frame_start and render_start in the same cycle: render_start wins.
- Pixel acceptance:
  - pix_ready = line_req = (state!=IDLE) && (free_banks!=0). line_bank=wbank.
  - A pixel is accepted when pix_valid && pix_ready.
  - On acceptance the following are registered and appear the next cycle (1-cycle latency): buf_we<=1, buf_addr<=(wbank ? LINE_WIDTH : 0)+x, buf_data<=pix_data. Otherwise buf_we<=0 and buf_addr/buf_data hold.
  - x increments per accepted pixel.
  - When the accepted pixel has x==LINE_WIDTH-1 (line complete): x<=0, wbank<=~wbank, and free_banks decrements.
- Display tracking:
  - In ARMED, the first scanline_start marks display start on bank 0: state<=RUN, sl_cnt<=0. No release occurs.
  - In RUN, each scanline_start increments sl_cnt. LPB = scale_l ? 4 : 2.
  - When the incremented value equals LPB, a release occurs: sl_cnt<=0 and free_banks increments, saturating at 2.
- Underrun:
  - At a release, let eff = free_banks minus 1 if a line completes in the same cycle, otherwise free_banks.
  - If eff>=1, underrun<=1. It is sticky until frame_start or reset.
- Simultaneous line completion and release: net free_banks unchanged.
- free_banks is 2 bits, range 0..2; it never wraps.
- x width is ADDR_W; its range is 0..LINE_WIDTH-1.
- pix_ready is combinational from registered state, with no dependency on pix_valid.

Test Plan:
1. Reset mid-line (x=100), then release reset -> all outputs 0; IDLE; pix_ready=0 until render_start.
2. render_start; stream 1280 pixels with data=index, pix_valid always high -> 1280 writes: addr 0..639 carry data 0..639 and addr 640..1279 carry data 640..1279. buf_we is one cycle after each accept. pix_ready drops after pixel 1279.
3. pixel_scale=0 after prefill: send scanline_start x3 -> the second pulse after display start releases bank 0. line_req=1, line_bank=0; writes resume at addr 0. underrun=0.
4. pixel_scale=1: release occurs only on the 4th pulse after display start. Changing pixel_scale mid-frame has no effect.
5. Withhold pixels after one release, then deliver 2 more releases -> underrun=1 at the second release. free_banks saturates at 2. A later frame_start clears underrun.
6. Last pixel of a line (x=639) accepted in the same cycle as a release with free_banks=1 -> no underrun; free_banks stays 1; wbank toggles.
